input_conditioner: RTL and testbench

- Multi-channel front end for asynchronous inputs such as buttons and switches.
- Per channel: a SYNC_STAGES-deep flip-flop synchronizer, a saturating-counter debouncer driven by a shared sample tick, and registered rising/falling edge pulses.
- Sits between the board I/O pins and user logic (FSMs, counters), so downstream logic sees clean levels and one-cycle pulses in the clk domain.

---
 rtl/input_conditioner.sv | 137 +++++++++++++
 tb/tb_input_conditioner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// input_conditioner: per-channel synchronizer, tick-sampled saturating debouncer
// and registered rise/fall pulses for asynchronous pins (buttons, switches).
// Optional auto-repeat on rise_pulse while a level is held: define COND_AUTOREPEAT_EN.
`timescale 1ns/1ps
module input_conditioner #(
    parameter int WIDTH          = 1,
    parameter int SYNC_STAGES    = 2,
    parameter int SAMPLE_PERIOD  = 25000,
    parameter int STABLE_SAMPLES = 150,
    parameter int REPEAT_DELAY   = 500,
    parameter int REPEAT_PERIOD  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] level_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);
    localparam int TW = $clog2(SAMPLE_PERIOD);
    localparam int CW = $clog2(STABLE_SAMPLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(STABLE_SAMPLES);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync;
    logic [TW-1:0]    tick_q, tick_d;
    logic             tick;
    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] lev_q;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] rep_hit;

    assign sync = sync_q[SYNC_STAGES-1];

    // Synchronizer chain: stage 0 samples the pin, the last stage feeds the debouncer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
        end else begin
            sync_q[0] <= async_in;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Shared sample tick: free-running 0..SAMPLE_PERIOD-1, tick on the last count.
    always_comb begin
        tick   = (tick_q == TICK_LAST);
        tick_d = tick ? '0 : tick_q + 1'b1;
    end

    // Debounce: any low sample clears immediately; high samples count on ticks and saturate.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i]     = cnt_q[i];
            level_out[i] = (cnt_q[i] == CNT_FULL);
            if (!sync[i]) begin
                cnt_d[i] = '0;
            end else if (tick && (cnt_q[i] != CNT_FULL)) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Tick counter and per-channel debounce counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= '0;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            tick_q <= tick_d;
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end

`ifdef COND_AUTOREPEAT_EN
    localparam int RW       = $clog2(REPEAT_DELAY + 1);
    localparam int RELOAD_I = (REPEAT_DELAY > REPEAT_PERIOD) ? (REPEAT_DELAY - REPEAT_PERIOD) : 0;
    localparam logic [RW-1:0] REP_FULL   = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_RELOAD = RW'(RELOAD_I);

    logic [RW-1:0] rep_q [WIDTH];
    logic [RW-1:0] rep_d [WIDTH];

    // Repeat timer: idle while released, counts ticks while held, fires and reloads at the delay.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            rep_d[i]   = rep_q[i];
            rep_hit[i] = 1'b0;
            if (!level_out[i]) begin
                rep_d[i] = '0;
            end else if (rep_q[i] == REP_FULL) begin
                rep_hit[i] = 1'b1;
                rep_d[i]   = REP_RELOAD;
            end else if (tick) begin
                rep_d[i] = rep_q[i] + 1'b1;
            end
        end
    end

    // Repeat timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) rep_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    assign rep_hit = '0;
`endif

    // Edge detection against the previous debounced level; repeat hits share the rise stage.
    always_comb begin
        rise_d = (level_out & ~lev_q) | rep_hit;
        fall_d = ~level_out & lev_q;
    end

    // Level history and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            lev_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            lev_q  <= level_out;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: cycle-level reference model feeds a scoreboard,
// plus directed latency/pulse checks. Define COND_AUTOREPEAT_EN for the repeat build.
`timescale 1ns/1ps
module tb_input_conditioner;
    localparam int SP = 4;
    localparam int SS = 3;
    localparam int RD = 2;
    localparam int RP = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] async_in = 2'b11;
    logic [1:0] level_out, rise_pulse, fall_pulse;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic [5:0] sb_q[$];

    int   m_s1[2], m_s2[2], m_cnt[2], m_rep[2], m_levh[2];
    int   m_tc;
    logic [1:0] m_rise, m_fall;

    input_conditioner #(
        .WIDTH(2), .SYNC_STAGES(2), .SAMPLE_PERIOD(SP), .STABLE_SAMPLES(SS),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .rst(rst), .async_in(async_in),
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: state after the coming clock edge, expected outputs pushed to the scoreboard.
    task automatic model_step(input logic r, input logic [1:0] a);
        logic [5:0] e;
        bit tk, lev_now, hit;
        tk = (m_tc == SP - 1);
        if (r) begin
            m_tc = 0;
            for (int i = 0; i < 2; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_cnt[i] = 0; m_rep[i] = 0; m_levh[i] = 0;
                m_rise[i] = 1'b0; m_fall[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                lev_now = (m_cnt[i] == SS);
                hit = 1'b0;
`ifdef COND_AUTOREPEAT_EN
                if (!lev_now) m_rep[i] = 0;
                else if (m_rep[i] == RD) begin
                    hit = 1'b1;
                    m_rep[i] = (RD > RP) ? RD - RP : 0;
                end else if (tk) m_rep[i] = m_rep[i] + 1;
`endif
                m_rise[i] = (lev_now && (m_levh[i] == 0)) || hit;
                m_fall[i] = !lev_now && (m_levh[i] != 0);
                m_levh[i] = lev_now ? 1 : 0;
                if (m_s2[i] == 0) m_cnt[i] = 0;
                else if (tk && m_cnt[i] < SS) m_cnt[i] = m_cnt[i] + 1;
                m_s2[i] = m_s1[i];
                m_s1[i] = a[i] ? 1 : 0;
            end
            m_tc = tk ? 0 : m_tc + 1;
        end
        for (int i = 0; i < 2; i++) begin
            e[4+i] = (m_cnt[i] == SS);
            e[2+i] = m_rise[i];
            e[i]   = m_fall[i];
        end
        sb_q.push_back(e);
    endtask

    // One clock: drive, predict, then compare the DUT output against the oldest prediction.
    task automatic step(input logic r, input logic [1:0] a);
        logic [5:0] e;
        rst = r;
        async_in = a;
        model_step(r, a);
        @(posedge clk);
        #1;
        cyc++;
        e = sb_q.pop_front();
        check($sformatf("sb@%0d", cyc), {level_out, rise_pulse, fall_pulse}, e);
    endtask

    initial begin
        int n, highs, rises;
        int p[$];

        // Reset with both inputs held high
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 2'b11);
            check("rst_level", level_out, 2'b00);
            check("rst_rise", rise_pulse, 2'b00);
            check("rst_fall", fall_pulse, 2'b00);
        end
        step(1'b0, 2'b00);
        check("post_rst_out", {level_out, rise_pulse, fall_pulse}, 6'd0);
        for (int k = 0; k < 10; k++) step(1'b0, 2'b00);

        // Channel 0 assertion latency, single rise pulse, channel 1 quiet
        n = 0; rises = 0;
        while (!level_out[0] && n < 30) begin
            step(1'b0, 2'b01);
            n++;
            rises += rise_pulse[0];
            highs = level_out[1] | rise_pulse[1] | fall_pulse[1];
            if (highs != 0) check("ch1_quiet", highs, 0);
        end
        check("ch0_assert_latency_11_14", (n >= 11 && n <= 14), 1'b1);
        check("no_rise_before_level", rises, 0);
        step(1'b0, 2'b01);
        check("ch0_rise_pulse", rise_pulse, 2'b01);
        step(1'b0, 2'b01);
        check("ch0_rise_one_cycle", rise_pulse, 2'b00);
        check("ch1_level_low", level_out[1], 1'b0);

        // One-cycle low glitch on a held level
        step(1'b0, 2'b00);
        n = 1;
        while (level_out[0] && n < 10) begin step(1'b0, 2'b01); n++; end
        check("glitch_fall_latency", n, 3);
        step(1'b0, 2'b01); n++;
        check("glitch_fall_pulse", fall_pulse, 2'b01);
        check("glitch_no_rise_with_fall", rise_pulse, 2'b00);
        step(1'b0, 2'b01); n++;
        check("glitch_fall_one_cycle", fall_pulse, 2'b00);
        while (!level_out[0] && n < 40) begin step(1'b0, 2'b01); n++; end
        check("reassert_latency_12_15", (n >= 12 && n <= 15), 1'b1);

        // Release and settle
        n = 0;
        while (level_out[0] && n < 10) begin step(1'b0, 2'b00); n++; end
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00);

        // Bounce every 3 cycles never qualifies
        highs = 0; rises = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, ((k / 3) % 2) ? 2'b01 : 2'b00);
            highs += level_out[0];
            rises += rise_pulse[0];
        end
        check("bounce_no_level", highs, 0);
        check("bounce_no_rise", rises, 0);
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00);

        // Both channels together
        n = 0;
        while (rise_pulse == 2'b00 && n < 30) begin step(1'b0, 2'b11); n++; end
        check("both_rise", rise_pulse, 2'b11);
        step(1'b0, 2'b11);
        check("both_rise_one_cycle", rise_pulse, 2'b00);
        n = 0;
        while (fall_pulse == 2'b00 && n < 10) begin step(1'b0, 2'b00); n++; end
        check("both_fall", fall_pulse, 2'b11);
        for (int k = 0; k < 6; k++) step(1'b0, 2'b00);

        // Long hold on channel 0, then reset mid-hold
        n = 0;
        while (!level_out[0] && n < 30) begin step(1'b0, 2'b01); n++; end
        check("hold_level_up", level_out[0], 1'b1);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 2'b01);
            if (rise_pulse[0]) p.push_back(cyc);
        end
`ifdef COND_AUTOREPEAT_EN
        check("repeat_count", p.size(), 9);
        if (p.size() >= 3) begin
            check("repeat_first_gap", p[1] - p[0], 8);
            check("repeat_period_gap", p[2] - p[1], 4);
        end else begin
            check("repeat_pulses_present", p.size(), 3);
        end
`else
        check("hold_single_rise", p.size(), 1);
`endif
        step(1'b1, 2'b01);
        check("midhold_rst_out", {level_out, rise_pulse, fall_pulse}, 6'd0);
        rises = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 2'b01);
            rises += rise_pulse[0] | fall_pulse[0];
        end
        check("midhold_rst_pulses_stop", rises, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
